// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1-to-8 TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_LANES = 8;
  localparam int SLOT_W    = 3;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/demux_slot_decode.sv
// 3-to-8 one-hot slot decoder with enable; drives per-lane write strobes.
module demux_slot_decode
  import tdm_pkg::*;
(
  input  logic                 en,
  input  slot_t                sel,
  output logic [NUM_LANES-1:0] onehot
);

  // One strobe per lane, asserted only when enabled and the slot matches.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_dec
    assign onehot[gi] = en && (sel == slot_t'(gi));
  end

endmodule

// File: rtl/tdm_demux1to8.sv
// Sequential 1-to-8 time-division demultiplexer: collects eight framed
// serial beats into shadow storage and publishes them as one registered
// parallel word with a valid/ready handshake.
module tdm_demux1to8
  import tdm_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  input  logic              frame_start,
  output logic              in_ready,
  output logic [DATA_W-1:0] o0,
  output logic [DATA_W-1:0] o1,
  output logic [DATA_W-1:0] o2,
  output logic [DATA_W-1:0] o3,
  output logic [DATA_W-1:0] o4,
  output logic [DATA_W-1:0] o5,
  output logic [DATA_W-1:0] o6,
  output logic [DATA_W-1:0] o7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s2,
  output logic              s1,
  output logic              s0,
  output logic              frame_err
);

  state_t              state_reg, state_next;
  slot_t               slot_reg, slot_next;
  logic                out_valid_reg, out_valid_next;
  logic                frame_err_reg, frame_err_next;
  logic [DATA_W-1:0]   shadow_reg [NUM_LANES-1];
  logic [DATA_W-1:0]   lane_reg   [NUM_LANES];

  logic                accept;
  logic                wr_en;
  slot_t               wr_sel;
  logic [NUM_LANES-1:0] wr_onehot;
  logic                complete;

  // Only the completing beat can stall: it needs the output word free.
  assign in_ready = !((state_reg == FILL) && (slot_reg == slot_t'(NUM_LANES-1)) &&
                      out_valid_reg && !out_ready);
  assign accept   = in_valid && in_ready;

  // A frame_start beat always lands in slot 0; stray beats in IDLE write nothing.
  assign wr_en    = accept && ((state_reg == FILL) || frame_start);
  assign wr_sel   = frame_start ? slot_t'(0) : slot_reg;

  demux_slot_decode u_decode (
    .en     (wr_en),
    .sel    (wr_sel),
    .onehot (wr_onehot)
  );

  // The slot-7 strobe doubles as the word-completion event.
  assign complete = wr_onehot[NUM_LANES-1];

  // Next-state logic for frame tracking, slot counter, error and valid.
  always_comb begin
    state_next     = state_reg;
    slot_next      = slot_reg;
    frame_err_next = 1'b0;
    out_valid_next = out_valid_reg;
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
    if (complete) begin
      out_valid_next = 1'b1;
    end
    if (accept) begin
      unique case (state_reg)
        IDLE: begin
          if (frame_start) begin
            slot_next  = slot_t'(1);
            state_next = FILL;
          end
        end
        FILL: begin
          if (frame_start) begin
            frame_err_next = 1'b1;
            slot_next      = slot_t'(1);
          end else if (slot_reg == slot_t'(NUM_LANES-1)) begin
            slot_next  = slot_t'(0);
            state_next = IDLE;
          end else begin
            slot_next = slot_reg + slot_t'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      slot_reg      <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slot_reg      <= slot_next;
      out_valid_reg <= out_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Shadow registers for slots 0..6; slot 7 goes straight to the output.
  for (genvar gi = 0; gi < NUM_LANES-1; gi++) begin : g_shadow
    // Capture the beat addressed to this slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_reg[gi] <= '0;
      end else if (wr_onehot[gi]) begin
        shadow_reg[gi] <= in;
      end
    end
  end

  // Output lanes load together, only on word completion.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    if (gi < NUM_LANES-1) begin : g_from_shadow
      // Publish the buffered slot when the frame completes.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (complete) begin
          lane_reg[gi] <= shadow_reg[gi];
        end
      end
    end else begin : g_from_input
      // Last slot is taken directly from the completing beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (complete) begin
          lane_reg[gi] <= in;
        end
      end
    end
  end

  assign o0 = lane_reg[0];
  assign o1 = lane_reg[1];
  assign o2 = lane_reg[2];
  assign o3 = lane_reg[3];
  assign o4 = lane_reg[4];
  assign o5 = lane_reg[5];
  assign o6 = lane_reg[6];
  assign o7 = lane_reg[7];

  assign out_valid = out_valid_reg;
  assign frame_err = frame_err_reg;
  assign {s2, s1, s0} = slot_reg;

endmodule

// File: tb/tb_tdm_demux1to8.sv
// Randomized self-checking bench for tdm_demux1to8 (DATA_W = 8) against a
// frame-level reference model.
module tb_tdm_demux1to8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       in_valid, frame_start, out_ready;
  logic       in_ready, out_valid, s2, s1, s0, frame_err;
  logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7;

  always #5 clk = ~clk;

  tdm_demux1to8 #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid),
    .frame_start(frame_start), .in_ready(in_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .out_valid(out_valid), .out_ready(out_ready),
    .s2(s2), .s1(s1), .s0(s0), .frame_err(frame_err)
  );

  // Reference model: pos = next slot of the open frame (0 means no frame open).
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_words = 0;
  bit         model_init = 0;
  int         pos = 0;
  logic [7:0] fbuf [8];
  logic [7:0] word [8];
  bit         wvalid = 0;
  bit         err = 0;
  bit         acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !(pos == 7 && wvalid && !out_ready);
  endfunction

  function automatic logic [63:0] packed_word();
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = word[k];
    return w;
  endfunction

  task automatic model_update();
    bit completed = 0;
    if (rst) begin
      pos = 0; wvalid = 0; err = 0; acc = 0;
      for (int k = 0; k < 8; k++) begin fbuf[k] = 8'h00; word[k] = 8'h00; end
      model_init = 1;
      return;
    end
    acc = in_valid && model_ready();
    err = 0;
    if (acc) begin
      if (frame_start) begin
        if (pos != 0) err = 1;
        fbuf[0] = din;
        pos = 1;
      end else if (pos != 0) begin
        fbuf[pos] = din;
        if (pos == 7) begin
          word = fbuf;
          completed = 1;
          pos = 0;
        end else begin
          pos++;
        end
      end
    end
    if (completed) begin
      wvalid = 1;
      n_words++;
      $display("word %0d: o7..o0 = %h", n_words, packed_word());
    end else if (wvalid && out_ready) begin
      wvalid = 0;
    end
  endtask

  // One clock cycle: check outputs, drive inputs, check in_ready, advance model.
  task automatic step(input logic r, input logic v, input logic fs,
                      input logic [7:0] d, input logic ordy);
    @(negedge clk);
    if (model_init) begin
      chk("lanes", {o7, o6, o5, o4, o3, o2, o1, o0}, packed_word());
      chk("out_valid", 64'(out_valid), 64'(wvalid));
      chk("frame_err", 64'(frame_err), 64'(err));
      chk("slot", 64'({s2, s1, s0}), 64'(pos));
    end
    rst = r; in_valid = v; frame_start = fs; din = d; out_ready = ordy;
    #1;
    if (model_init && !r) chk("in_ready", 64'(in_ready), 64'(model_ready()));
    @(posedge clk);
    #0 model_update();
  endtask

  task automatic beat(input logic [7:0] d, input logic fs, input logic ordy);
    step(1'b0, 1'b1, fs, d, ordy);
  endtask

  task automatic frame(input logic [7:0] base, input logic ordy);
    for (int k = 0; k < 8; k++) beat(base + 8'(k), k == 0, ordy);
  endtask

  initial begin
    rst = 1; din = 0; in_valid = 0; frame_start = 0; out_ready = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Basic frame 10..17.
    frame(8'h10, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Three back-to-back frames.
    frame(8'h20, 1);
    frame(8'h40, 1);
    frame(8'h60, 1);
    step(0, 0, 0, 0, 1);

    // Backpressure: first word pending, second frame stalls at slot 7.
    frame(8'h80, 0);
    for (int k = 0; k < 7; k++) beat(8'h90 + 8'(k), k == 0, 0);
    for (int k = 0; k < 3; k++) beat(8'h97, 0, 0);
    beat(8'h97, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // frame_start reasserted at slot 4 with AA.
    for (int k = 0; k < 4; k++) beat(8'hB0 + 8'(k), k == 0, 1);
    beat(8'hAA, 1, 1);
    for (int k = 1; k < 8; k++) beat(8'hC0 + 8'(k), 0, 1);
    step(0, 0, 0, 0, 1);

    // Stray beats in IDLE, then a valid frame.
    for (int k = 0; k < 5; k++) beat(8'(k + 8'hE0), 0, 1);
    frame(8'hD0, 1);
    step(0, 0, 0, 0, 1);

    // Reset at slot 5 with a word pending.
    frame(8'h30, 0);
    for (int k = 0; k < 5; k++) beat(8'h50 + 8'(k), k == 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    frame(8'h70, 1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic v, fs, ordy;
      v    = ($urandom_range(0, 9) < 8);
      fs   = (pos == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      step(0, v, fs, 8'($urandom), ordy);
    end
    step(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
